tnoc_vc_output_arbiter: RTL
===========================

// Module: tnoc_vc_output_arbiter
// PURPOSE
//  Output stage downstream of the per-virtual-channel FIFOs in a router port.
//  Pops flits from CHANNELS FIFOs (first-word-fall-through: i_data valid while !i_empty),
//  arbitrates round-robin per packet (grant held until tail flit), and checks per-VC
//  downstream credits. Drives one registered flit per cycle onto the link.
// PARAMETERS
//  CHANNELS  2        number of virtual channels / upstream FIFOs (>=2)
//  WIDTH     8        flit width; must match the upstream FIFO WIDTH
//  TAIL_BIT  WIDTH-1  bit index of the tail-flit marker inside a flit
//  CREDITS   4        downstream buffer depth per VC = initial credit count (>=1)
// PORTS
//  clk              in   1                clock
//  rst_n            in   1                asynchronous active-low reset
//  i_clear          in   1                synchronous clear of all state (shared with FIFOs)
//  i_empty          in   CHANNELS         FIFO empty flags
//  i_data           in   CHANNELS*WIDTH   FIFO head flits, VC c at [c*WIDTH +: WIDTH]
//  o_pop            out  CHANNELS         pop strobes, at most one bit set (combinational)
//  o_valid          out  1                flit valid on link (registered)
//  o_vc             out  $clog2(CHANNELS) VC of o_data (registered)
//  o_data           out  WIDTH            flit on link (registered)
//  i_credit_return  in   CHANNELS         one-cycle pulse per freed downstream slot, per VC
// BEHAVIOUR
//  Reset/clear: o_valid=0, o_vc=0, o_data=0, state IDLE, rr pointer=CHANNELS-1 (VC0 first),
//   credit[c]=CREDITS. i_clear takes priority over all other updates; o_pop=0 while i_clear.
//  eligible[c] = !i_empty[c] && credit[c]!=0.
//  IDLE: pick first eligible VC searching pointer+1, +2, ... (wrap at CHANNELS-1 -> 0);
//   assert o_pop[g] same cycle. Popped flit tail=1 -> stay IDLE; tail=0 -> LOCKED(g).
//   Pointer <- g on every pop (single-flit packets also advance it).
//  LOCKED(g): only VC g may pop; o_pop[g]=eligible[g]; other VCs starve. Tail flit
//   popped -> IDLE. Empty FIFO or zero credit mid-packet: wait, no timeout.
//  Output: cycle after pop, o_valid=1, o_data=popped flit, o_vc=g; no pop -> o_valid=0,
//   o_data/o_vc hold. Latency 1 cycle pop->link; throughput 1 flit/cycle, no bubbles.
//  Credits: width $clog2(CREDITS+1). Pop only -> -1; return only -> +1; both same VC
//   same cycle -> unchanged. Return at credit==CREDITS: ignored (saturate) + assertion.
//   Credit 0 blocks that VC; the returning pulse makes it eligible next cycle.
//  No pop ever issued when i_empty[c]=1 (FIFO would ignore it; still an assertion).
//  Reset mid-packet: lock lost, next packet starts fresh in IDLE.
// STRUCTURE
//  Shared package: state enum (IDLE, LOCKED), credit-width and VC-index-width helpers.
//  Sub-module tnoc_round_robin_arbiter: request vector + pointer in, one-hot grant out,
//  pointer update on i_update; reusable by the router switch allocator.
// TESTING
//  1 Reset, VC0 holds 3-flit packet (tail on flit 3) -> o_pop[0] 3 consecutive cycles,
//    o_valid 3 cycles starting 1 cycle later, o_vc=0, credit[0]=1.
//  2 VC0,VC1 each 2 single-flit packets -> link order VC0,VC1,VC0,VC1, no idle cycles.
//  3 VC0 4-flit packet, VC1 requests at flit 2 -> VC1 waits until VC0 tail, then granted.
//  4 CREDITS=4, VC0 6 single flits, no returns -> 4 sent, stall; one return pulse ->
//    5th sent the following cycle.
//  5 Pop and credit return on VC1 in the same cycle at credit=2 -> credit stays 2;
//    return at credit=4 -> stays 4, assertion fires.
//  6 i_clear mid-packet (LOCKED VC1) -> next cycle IDLE, credits=4, o_valid=0,
//    VC0 granted first afterwards.

Source files
------------

// File: rtl/tnoc_vc_output_arbiter_pkg.sv
// Shared types and width helpers for the VC output arbiter and its round-robin sub-arbiter.
package tnoc_vc_output_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned credit_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

    function automatic int unsigned vc_index_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// Round-robin arbiter: searches from pointer+1 upward with wrap, pointer moves to the winner on update.
module tnoc_round_robin_arbiter
    import tnoc_vc_output_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [N-1:0]                 request,
    input  logic                         update,
    output logic [N-1:0]                 grant_c,
    output logic [vc_index_width(N)-1:0] grant_index_c
);

    localparam int unsigned IW = vc_index_width(N);

    logic [IW-1:0] pointer;
    logic [N-1:0]  upper_c;
    logic [N-1:0]  pick_c;
    logic          found_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer <= IW'(N - 1);
        end else if (clear) begin
            pointer <= IW'(N - 1);
        end else if (update) begin
            pointer <= grant_index_c;
        end
    end

    // Requests above the pointer take precedence; otherwise wrap to the lowest request.
    always_comb begin
        upper_c       = '0;
        grant_c       = '0;
        grant_index_c = '0;
        found_c       = 1'b0;
        for (int c = 0; c < int'(N); c++) begin
            upper_c[c] = request[c] && (IW'(c) > pointer);
        end
        pick_c = (upper_c != '0) ? upper_c : request;
        for (int c = 0; c < int'(N); c++) begin
            if (pick_c[c] && !found_c) begin
                grant_c[c]    = 1'b1;
                grant_index_c = IW'(c);
                found_c       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tnoc_vc_output_arbiter.sv
// Router output stage: per-packet round-robin over VC FIFOs with per-VC downstream credit tracking.
module tnoc_vc_output_arbiter
    import tnoc_vc_output_arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TAIL_BIT = WIDTH - 1,
    parameter int unsigned CREDITS  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic [CHANNELS-1:0]         i_empty,
    input  logic [CHANNELS*WIDTH-1:0]   i_data,
    output logic [CHANNELS-1:0]         o_pop,
    output logic                        o_valid,
    output logic [$clog2(CHANNELS)-1:0] o_vc,
    output logic [WIDTH-1:0]            o_data,
    input  logic [CHANNELS-1:0]         i_credit_return
);

    localparam int unsigned VW = vc_index_width(CHANNELS);
    localparam int unsigned CW = credit_width(CREDITS);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [VW-1:0]       lock_vc_q;
    logic [VW-1:0]       lock_vc_d;
    logic [CW-1:0]       credit [CHANNELS];
    logic [CHANNELS-1:0] eligible_c;
    logic [CHANNELS-1:0] grant_c;
    logic [VW-1:0]       grant_index_c;
    logic [CHANNELS-1:0] pop_c;
    logic                update_c;
    logic [VW-1:0]       sel_vc_c;
    logic [WIDTH-1:0]    sel_data_c;

    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            eligible_c[c] = !i_empty[c] && (credit[c] != '0);
        end
    end

    tnoc_round_robin_arbiter #(
        .N (CHANNELS)
    ) u_rr_arbiter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (i_clear),
        .request       (eligible_c),
        .update        (update_c),
        .grant_c       (grant_c),
        .grant_index_c (grant_index_c)
    );

    // Head flit of the candidate VC; its tail bit decides whether the grant is held.
    always_comb begin
        sel_vc_c   = (state_q == IDLE) ? grant_index_c : lock_vc_q;
        sel_data_c = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (VW'(c) == sel_vc_c) begin
                sel_data_c = i_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_vc_q <= '0;
        end else if (i_clear) begin
            state_q   <= IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        pop_c     = '0;
        update_c  = 1'b0;
        if (!i_clear) begin
            case (state_q)
                IDLE: begin
                    if (grant_c != '0) begin
                        pop_c     = grant_c;
                        update_c  = 1'b1;
                        lock_vc_d = grant_index_c;
                        if (!sel_data_c[TAIL_BIT]) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    pop_c[lock_vc_q] = eligible_c[lock_vc_q];
                    if (eligible_c[lock_vc_q] && sel_data_c[TAIL_BIT]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_pop = pop_c;

    // A simultaneous pop and return on one VC cancel; returns at full credit saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                credit[c] <= CW'(CREDITS);
            end
        end else if (i_clear) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                credit[c] <= CW'(CREDITS);
            end
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (pop_c[c] && !i_credit_return[c]) begin
                    credit[c] <= credit[c] - CW'(1);
                end else if (i_credit_return[c] && !pop_c[c] && (credit[c] != CW'(CREDITS))) begin
                    credit[c] <= credit[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_vc    <= '0;
            o_data  <= '0;
        end else if (i_clear) begin
            o_valid <= 1'b0;
            o_vc    <= '0;
            o_data  <= '0;
        end else begin
            o_valid <= |pop_c;
            if (|pop_c) begin
                o_vc   <= sel_vc_c;
                o_data <= sel_data_c;
            end
        end
    end

    // Protocol checks: never pop an empty FIFO; flag credit returns beyond the buffer depth.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clear) begin
            assert ((pop_c & i_empty) == '0)
                else $error("pop issued to an empty VC FIFO");
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (i_credit_return[c] && !pop_c[c]) begin
                    assert (credit[c] != CW'(CREDITS))
                        else $warning("credit return on VC %0d ignored, counter already full", c);
                end
            end
        end
    end

endmodule
